// File: rtl/hybrid_pkg.sv
// Shared definitions for the Hybrid_RSA_AES datapath: block geometry and the
// UART byte-serialiser state encoding.
package hybrid_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int BYTES_PER_BLOCK = AES_BLOCK_BITS / 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/plaintext_uart_tx_if.sv
// Bundle between the decrypt core (master) and the plaintext UART sender (slave).
// The source cannot be stalled, so there is no ready signal.
interface plaintext_uart_tx_if
    import hybrid_pkg::*;
#(
    parameter int BLOCK_BITS = AES_BLOCK_BITS
);

    logic [BLOCK_BITS-1:0] plaintext;
    logic                  plaintext_valid;
    logic                  tx;
    logic                  busy;
    logic                  block_done;
    logic                  overflow;

    modport master (
        output plaintext,
        output plaintext_valid,
        input  tx,
        input  busy,
        input  block_done,
        input  overflow
    );

    modport slave (
        input  plaintext,
        input  plaintext_valid,
        output tx,
        output busy,
        output block_done,
        output overflow
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start request is taken either from IDLE or on the
// last clock of a stop bit, so consecutive frames run with no idle gap.
// byte_done is a registered pulse covering the last clock of the stop bit.
module uart_tx_byte
    import hybrid_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    tx_state_e         state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              tx_q, tx_n;
    logic              done_q, done_n;

    // State and datapath registers; reset parks the line high in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
        end
    end

    // Next-state logic; the next tx level is decided here so tx is a pure flop.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = tx_q;
        done_n  = (state == STOP) && (baud_cnt == BAUD_PRE);
        if (state != IDLE) begin
            baud_n = (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = START;
                    baud_n  = '0;
                    shreg_n = data;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    if (start) begin
                        state_n = START;
                        shreg_n = data;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx        = tx_q;
    assign byte_done = done_q;

endmodule

// File: rtl/plaintext_uart_tx.sv
// Sends each decrypted block to the host as consecutive 8N1 frames, most
// significant byte first. One block may wait in a pending slot while another
// is on the wire; a block arriving with both slots full is dropped and the
// sticky overflow flag is raised.
module plaintext_uart_tx
    import hybrid_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int BLOCK_BITS   = AES_BLOCK_BITS
) (
    input  logic               clk,
    input  logic               rst,
    plaintext_uart_tx_if.slave bus
);

    localparam int         NUM_BYTES = BLOCK_BITS / 8;
    localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

    logic [NUM_BYTES-1:0][7:0] active_buf;
    logic [NUM_BYTES-1:0][7:0] pending_buf;
    logic                      active_full;
    logic                      pending_full;
    logic [3:0]                byte_cnt;
    logic [3:0]                next_idx;
    logic                      overflow_q;
    logic                      byte_done;
    logic                      block_end;
    logic                      byte_start;
    logic [7:0]                byte_data;

    assign next_idx  = byte_cnt + 4'd1;
    assign block_end = byte_done && (byte_cnt == LAST_BYTE);

    // Pick the byte to launch: a fresh block's first byte from idle, the next
    // block on the final stop clock, or the next byte of the current block.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = '0;
        if (!active_full) begin
            if (bus.plaintext_valid) begin
                byte_start = 1'b1;
                byte_data  = bus.plaintext[BLOCK_BITS-1 -: 8];
            end
        end else if (block_end) begin
            if (pending_full) begin
                byte_start = 1'b1;
                byte_data  = pending_buf[NUM_BYTES-1];
            end else if (bus.plaintext_valid) begin
                byte_start = 1'b1;
                byte_data  = bus.plaintext[BLOCK_BITS-1 -: 8];
            end
        end else if (byte_done) begin
            byte_start = 1'b1;
            byte_data  = active_buf[LAST_BYTE - next_idx];
        end
    end

    // Buffer occupancy, byte position and overflow; a block finishing frees the
    // pending slot in the same clock, so an arrival then is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_buf   <= '0;
            pending_buf  <= '0;
            active_full  <= 1'b0;
            pending_full <= 1'b0;
            byte_cnt     <= '0;
            overflow_q   <= 1'b0;
        end else if (!active_full) begin
            if (bus.plaintext_valid) begin
                active_buf  <= bus.plaintext;
                active_full <= 1'b1;
                byte_cnt    <= '0;
            end
        end else if (block_end) begin
            byte_cnt <= '0;
            if (pending_full) begin
                active_buf   <= pending_buf;
                pending_full <= bus.plaintext_valid;
                if (bus.plaintext_valid) begin
                    pending_buf <= bus.plaintext;
                end
            end else if (bus.plaintext_valid) begin
                active_buf <= bus.plaintext;
            end else begin
                active_full <= 1'b0;
            end
        end else begin
            if (byte_done) begin
                byte_cnt <= next_idx;
            end
            if (bus.plaintext_valid) begin
                if (!pending_full) begin
                    pending_buf  <= bus.plaintext;
                    pending_full <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .start    (byte_start),
        .data     (byte_data),
        .tx       (bus.tx),
        .byte_done(byte_done)
    );

    assign bus.busy       = active_full;
    assign bus.block_done = block_end;
    assign bus.overflow   = overflow_q;

endmodule
